dmem_responder: RTL and testbench

- Memory-side responder for the data-cache refill/write-back interface.
- Accepts one 256-bit line request at a time from the cache controller (the initiator) and models a fixed access latency.
- Performs the read or write on a line-organised backing array, then returns a single-cycle ack.
- Sits between the dcache controller and the top-level bench; the backing array is named `memory` so benches can preload and flush it hierarchically.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_latency_ctr.sv | 28 ++
 rtl/dmem_responder.sv | 99 +++++++++
 tb/tb_dmem_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: line geometry, FSM states and
// the request record latched at capture time.
package dmem_pkg;

    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;
    localparam int INDEX_MAX   = 32 - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    typedef struct packed {
        logic [INDEX_MAX-1:0] index;
        logic                 write;
        logic [LINE_BITS-1:0] data;
    } req_t;

endpackage

// File: rtl/dmem_latency_ctr.sv
// Access-latency counter: loads to 1 on capture, counts while busy and flags
// the edge on which the count will reach LATENCY.
module dmem_latency_ctr #(
    parameter int LATENCY = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    output logic done
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= 8'd1;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

    // High one edge early so the access lands on the edge that reaches LATENCY.
    assign done = (count == 8'(LATENCY - 1));

endmodule

// File: rtl/dmem_responder.sv
// Line-organised memory model for dcache refill/write-back: one request at a
// time, fixed latency, single-cycle ack.
module dmem_responder #(
    parameter int LINE_BITS = 256,
    parameter int DEPTH     = 512,
    parameter int LATENCY   = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o
);

    import dmem_pkg::*;

    localparam int  IDX_BITS = $clog2(DEPTH);
    localparam bit  FAST     = (LATENCY == 1);

    state_t               state, state_nxt;
    req_t                 req;
    logic [LINE_BITS-1:0] memory [DEPTH];

    logic                 capture, access, done;
    logic                 acc_write;
    logic [IDX_BITS-1:0]  acc_index;
    logic [LINE_BITS-1:0] acc_data;
    logic                 unused_bits;

    assign capture = (state == IDLE) && enable_i;
    assign ack_o   = (state == ACK);

    dmem_latency_ctr #(.LATENCY(LATENCY)) u_ctr (
        .clk   (clk_i),
        .rst_n (rst_i),
        .load  (capture),
        .inc   (state == BUSY),
        .done  (done)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // A single-edge latency has no BUSY phase, so the access uses live inputs.
    always_comb begin
        state_nxt = state;
        access    = 1'b0;
        acc_index = req.index[IDX_BITS-1:0];
        acc_write = req.write;
        acc_data  = req.data;
        case (state)
            IDLE: if (enable_i) begin
                if (FAST) begin
                    state_nxt = ACK;
                    access    = 1'b1;
                    acc_index = addr_i[OFFSET_BITS +: IDX_BITS];
                    acc_write = write_i;
                    acc_data  = data_i;
                end else begin
                    state_nxt = BUSY;
                end
            end
            BUSY: if (done) begin
                state_nxt = ACK;
                access    = 1'b1;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req    <= '0;
            data_o <= '0;
        end else begin
            if (capture) begin
                req.index <= INDEX_MAX'(addr_i[OFFSET_BITS +: IDX_BITS]);
                req.write <= write_i;
                req.data  <= data_i;
            end
            if (access && !acc_write) data_o <= memory[acc_index];
        end
    end

    // Backing store is deliberately not reset; benches preload it directly.
    always_ff @(posedge clk_i) begin
        if (rst_i && access && acc_write) memory[acc_index] <= acc_data;
    end

    assign unused_bits = ^{addr_i[31:OFFSET_BITS+IDX_BITS], addr_i[OFFSET_BITS-1:0],
                           req.index[INDEX_MAX-1:IDX_BITS]};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of line requests with a cycle-stamped
// scoreboard, plus hand sequences for back-to-back, latching, resets, LATENCY=1.
module tb_dmem_responder;

    localparam int LAT = 10;

    localparam logic [255:0] L0  = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam logic [255:0] L1  = 256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222_3333_4444_5555_6666_7777_0000;
    localparam logic [255:0] L2  = 256'hECFA_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2;
    localparam logic [255:0] L16 = 256'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam logic [255:0] L17 = 256'h0000_0110_0220_0330_0440_0550_0660_0770_0880_0990_0AA0_0BB0_0CC0_0DD0_0EE0_0FF0;
    localparam logic [255:0] WV  = 256'h0000_1001_2002_3003_4004_5005_6006_7007_8008_9009_A00A_B00B_C00C_D00D_E00E_F00F;

    typedef struct {
        logic [31:0]  addr;
        logic         write;
        logic [255:0] wdata;
        logic [255:0] exp;
    } vec_t;

    typedef struct {
        int           cyc;
        logic         write;
        logic [255:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] wdata = '0;
    logic         enable = 1'b0, write = 1'b0;
    logic         ack;
    logic [255:0] rdata;

    logic [31:0]  addr1 = '0;
    logic [255:0] wdata1 = '0;
    logic         en1 = 1'b0, wr1 = 1'b0;
    logic         ack1;
    logic [255:0] rdata1;

    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;
    exp_t         sb[$];
    exp_t         mon_e;
    logic [255:0] last_data = '0;
    vec_t         tbl[7];

    dmem_responder #(.LINE_BITS(256), .DEPTH(512), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst_i), .addr_i(addr), .data_i(wdata),
        .enable_i(enable), .write_i(write), .ack_o(ack), .data_o(rdata)
    );

    dmem_responder #(.LINE_BITS(256), .DEPTH(512), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .addr_i(addr1), .data_i(wdata1),
        .enable_i(en1), .write_i(wr1), .ack_o(ack1), .data_o(rdata1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every ack must match the oldest outstanding expectation, in time and data.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected ack at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("ack cycle", 256'(cyc), 256'(mon_e.cyc));
                if (mon_e.write) chk("data_o held on write ack", rdata, last_data);
                else             chk("read data", rdata, mon_e.data);
            end
        end
        last_data = rdata;
    end

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ack timeout", 256'd0, 256'd1);
    endtask

    task automatic push(input int c, input logic w, input logic [255:0] d);
        exp_t e;
        e.cyc = c;
        e.write = w;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_req(input vec_t v);
        bit ok;
        addr = v.addr;
        write = v.write;
        wdata = v.wdata;
        enable = 1'b1;
        push(cyc + LAT, v.write, v.exp);
        wait_ack(ok);
        enable = 1'b0;
        @(negedge clk);
        chk("ack one cycle", 256'(ack), 256'd0);
    endtask

    task automatic lat1_req(input logic [31:0] a, input logic w, input logic [255:0] d,
                            input logic [255:0] exp);
        addr1 = a;
        wr1 = w;
        wdata1 = d;
        en1 = 1'b1;
        @(negedge clk);
        chk("lat1 ack next cycle", 256'(ack1), 256'd1);
        chk("lat1 data", rdata1, exp);
        en1 = 1'b0;
        @(negedge clk);
        chk("lat1 ack one cycle", 256'(ack1), 256'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        vec_t v;

        tbl[0] = '{32'h0000_0020, 1'b0, '0, L1};
        tbl[1] = '{32'h0000_0400, 1'b1, WV, '0};
        tbl[2] = '{32'h0000_0400, 1'b0, '0, WV};
        tbl[3] = '{32'h0000_0000, 1'b0, '0, L0};
        tbl[4] = '{32'h0000_4020, 1'b0, '0, L1};
        tbl[5] = '{32'h0000_8400, 1'b1, L2, '0};
        tbl[6] = '{32'h0000_0400, 1'b0, '0, L2};

        repeat (3) @(negedge clk);
        chk("reset ack", 256'(ack), 256'd0);
        chk("reset data", rdata, 256'd0);
        chk("reset ack lat1", 256'(ack1), 256'd0);
        chk("reset data lat1", rdata1, 256'd0);

        dut.memory[0]  = L0;
        dut.memory[1]  = L1;
        dut.memory[2]  = L2;
        dut.memory[16] = L16;
        dut.memory[17] = L17;
        dut1.memory[0] = L0;
        rst_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) do_req(tbl[i]);

        // enable held across ack: second capture on the first IDLE edge
        addr = 32'h20;
        write = 1'b0;
        enable = 1'b1;
        push(cyc + LAT, 1'b0, L1);
        push(cyc + 2 * LAT + 1, 1'b0, L1);
        wait_ack(ok);
        wait_ack(ok);
        enable = 1'b0;
        @(negedge clk);
        chk("b2b no extra ack", 256'(ack), 256'd0);

        // fields changed mid-BUSY must be ignored
        addr = 32'h40;
        write = 1'b0;
        enable = 1'b1;
        push(cyc + LAT, 1'b0, L2);
        repeat (3) @(negedge clk);
        addr = 32'h200;
        write = 1'b1;
        wdata = '1;
        wait_ack(ok);
        enable = 1'b0;
        write = 1'b0;
        @(negedge clk);
        v = '{32'h200, 1'b0, '0, L16};
        do_req(v);

        // reset mid-BUSY aborts the write
        addr = 32'h220;
        write = 1'b1;
        wdata = WV;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_i = 1'b0;
        #1;
        chk("midbusy reset ack", 256'(ack), 256'd0);
        chk("midbusy reset data", rdata, 256'd0);
        enable = 1'b0;
        write = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        v = '{32'h220, 1'b0, '0, L17};
        do_req(v);

        // reset during ACK drops ack immediately
        addr = 32'h20;
        enable = 1'b1;
        push(cyc + LAT, 1'b0, L1);
        wait_ack(ok);
        #2 rst_i = 1'b0;
        #1;
        chk("ack-state reset ack", 256'(ack), 256'd0);
        chk("ack-state reset data", rdata, 256'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);

        // LATENCY=1 instance, including address aliasing onto line 0
        lat1_req(32'h0, 1'b0, '0, L0);
        lat1_req(32'h4000, 1'b1, WV, L0);
        lat1_req(32'h0, 1'b0, '0, WV);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 256'(sb.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
